shift_sequencer: RTL

Multi-cycle controller that wraps the shared combinational shifter (`shiftUnit`) and adds rotate operations by sequencing it over two passes. It uses a valid/ready request channel and a valid/ready result channel with backpressure, and supports a synchronous flush. It sits in the execute stage beside the ALU and serves bit-manipulation instructions (ROL/ROR) as well as plain shifts.

---
 rtl/shift_sequencer_pkg.sv | 7 +
 rtl/shift_sequencer_shift_unit.sv | 20 ++
 rtl/shift_sequencer.sv | 87 ++++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: shared types for the shift/rotate sequencer and its shifter
//   shiftOp_e : request opcode (plain shifts and rotates)
//   unit_op_e : operation select of the combinational shifter
package shift_sequencer_pkg;
  typedef enum logic [2:0] {SH_SLL, SH_SRL, SH_SRA, SH_ROL, SH_ROR} shiftOp_e;
  typedef enum logic [1:0] {OP0, OP1, OP2} unit_op_e;
endpackage

// File: rtl/shift_sequencer_shift_unit.sv
// shiftUnit: combinational 32-bit shifter (OP0 sll, OP1 srl, OP2 sra)
//   operation_i      : shift kind
//   first_operand_i  : value to shift
//   second_operand_i : shift amount
//   result_o         : shifted value
module shiftUnit
  import shift_sequencer_pkg::*;
(
  input  unit_op_e    operation_i,
  input  logic [31:0] first_operand_i,
  input  logic [4:0]  second_operand_i,
  output logic [31:0] result_o
);
  logic [31:0] sra;
  // kept apart from the select so the unsigned ternary cannot turn >>> logical
  assign sra = $signed(first_operand_i) >>> second_operand_i;
  always_comb
    result_o = operation_i == OP0 ? first_operand_i << second_operand_i :
               operation_i == OP1 ? first_operand_i >> second_operand_i : sra;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences shiftUnit over one or two passes for shifts and rotates
//   clk, reset_n        : clock, async active-low reset
//   flush_i             : synchronous abort back to idle
//   valid_i/ready_o     : request handshake with operand_i, amount_i, op_i
//   valid_o/ready_i     : result handshake with registered result_o
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] operand_i,
  input  logic [4:0]  amount_i,
  input  shiftOp_e    op_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o
);
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_e;
  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d, opnd_q, opnd_d;
  logic [4:0]  amt_q, amt_d;
  shiftOp_e    op_q, op_d;
  logic        valid_q, valid_d;
  unit_op_e    unit_op;
  logic [4:0]  unit_amt;
  logic [31:0] unit_out;
  logic        is_rot;
  assign is_rot = op_q == SH_ROL || op_q == SH_ROR;
  // second pass supplies the wrapped-around bits: amount 32-n, which is -n in 5 bits,
  // shifting the opposite way from the first pass
  always_comb begin
    unit_amt = state_q == PASS2 ? 5'd0 - amt_q : amt_q;
    unit_op  = op_q == SH_SRA ? OP2 :
               ((op_q == SH_SLL || op_q == SH_ROL) ^ (state_q == PASS2)) ? OP0 : OP1;
  end
  shiftUnit u_shift (
    .operation_i      (unit_op),
    .first_operand_i  (opnd_q),
    .second_operand_i (unit_amt),
    .result_o         (unit_out)
  );
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    amt_d   = amt_q;
    op_d    = op_q;
    if (flush_i) state_d = IDLE;
    else if (state_q == IDLE) begin
      if (valid_i) begin
        opnd_d  = operand_i;
        amt_d   = amount_i;
        op_d    = op_i;
        state_d = PASS1;
      end
    end else if (state_q == PASS1) begin
      acc_d   = unit_out;
      state_d = is_rot && amt_q != 5'd0 ? PASS2 : DONE;
    end else if (state_q == PASS2) begin
      acc_d   = acc_q | unit_out;
      state_d = DONE;
    end else if (ready_i) state_d = IDLE;
    valid_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      amt_q   <= '0;
      op_q    <= SH_SLL;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  assign ready_o  = state_q == IDLE;
  assign valid_o  = valid_q;
  assign result_o = acc_q;
endmodule
